// File: rtl/bin_bcd_scan_display.sv
// Sequential double-dabble binary-to-BCD converter feeding a multiplexed,
// registered 7-segment scan driver with leading-zero blanking and overflow dashes.
module bin_bcd_scan_display #(
    parameter int DIGITS   = 4,
    parameter int WIDTH    = 14,
    parameter int SCAN_DIV = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WIDTH-1:0]  bin,
    input  logic              blank_lz,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an
);

    // Decimal digits needed for the largest WIDTH-bit value (2^WIDTH - 1).
    function automatic int calc_nbcd(input int w);
        int v;
        int n;
        v = (1 << w) - 1;
        n = 0;
        while (v > 0) begin
            v = v / 10;
            n++;
        end
        return n;
    endfunction

    localparam int NBCD     = calc_nbcd(WIDTH);
    localparam int CNT_W    = $clog2(WIDTH + 1);
    localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W    = $clog2(SCAN_DIV);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    localparam logic [6:0] SEG_DASH = 7'b0000001;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CONV = 1'b1
    } state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Converter state
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [WIDTH-1:0]    bin_sh_q, bin_sh_d;
    logic [4*NBCD-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                blank_lz_q, blank_lz_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
    logic [4*DIGITS-1:0] disp_q, disp_d;
    logic [DIGITS-1:0]   mask_q, mask_d;

    logic [4*NBCD-1:0]   bcd_adj;
    logic [4*NBCD-1:0]   bcd_shift;
    logic                lost_bit;
    logic [4*DIGITS-1:0] disp_new;
    logic [DIGITS-1:0]   mask_new;
    logic                ovf_new;

    // ------------------------------------------------------------------
    // Scan state
    // ------------------------------------------------------------------
    logic [PRE_W-1:0]    presc_q, presc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [3:0]          cur_digit;
    logic                cur_blank;

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    for (genvar gi = 0; gi < NBCD; gi++) begin : g_adj
        assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                    (bcd_q[gi*4 +: 4] + 4'd3) : bcd_q[gi*4 +: 4];
    end

    assign bcd_shift = {bcd_adj[4*NBCD-2:0], bin_sh_q[WIDTH-1]};
    // Never set with a correctly sized accumulator; folded into ovf so no bit is silently dropped.
    assign lost_bit  = bcd_adj[4*NBCD-1];

    // Displayed digits beyond the accumulator's reach are always zero.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_disp
        if (gi < NBCD) begin : g_src
            assign disp_new[gi*4 +: 4] = bcd_shift[gi*4 +: 4];
        end else begin : g_zero
            assign disp_new[gi*4 +: 4] = 4'd0;
        end
    end

    if (NBCD > DIGITS) begin : g_ovf
        assign ovf_new = lost_bit | (|bcd_shift[4*NBCD-1:4*DIGITS]);
    end else begin : g_no_ovf
        assign ovf_new = lost_bit;
    end

    // Walk down from the top digit; blank until the first nonzero digit, never digit 0.
    always_comb begin
        logic seen;
        seen     = 1'b0;
        mask_new = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (disp_new[i*4 +: 4] != 4'd0) begin
                seen = 1'b1;
            end
            mask_new[i] = blank_lz_q & ~seen;
        end
    end

    always_comb begin
        state_d    = state_q;
        bin_sh_d   = bin_sh_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        blank_lz_d = blank_lz_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        disp_d     = disp_q;
        mask_d     = mask_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_CONV;
                    bin_sh_d   = bin;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    blank_lz_d = blank_lz;
                end
            end
            S_CONV: begin
                bin_sh_d = {bin_sh_q[WIDTH-2:0], 1'b0};
                bcd_d    = bcd_shift;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // Final shift: publish value, blank mask and ovf on the done edge.
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    ovf_d   = ovf_new;
                    disp_d  = disp_new;
                    mask_d  = mask_new;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Free-running prescaler and digit index, unaffected by conversions.
    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        if (presc_q == PRE_LAST) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : (idx_q + 1'b1);
        end
    end

    always_comb begin
        cur_digit = 4'd0;
        cur_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                cur_digit = disp_d[i*4 +: 4];
                cur_blank = mask_d[i];
            end
        end
    end

    // seg is built from next-state values so it always matches the registered display.
    always_comb begin
        if (ovf_d) begin
            seg_d = SEG_DASH;
        end else if (cur_blank) begin
            seg_d = 7'b0000000;
        end else begin
            seg_d = seg_decode(cur_digit);
        end
    end

    if (DIGITS == 1) begin : g_an_single
        assign an_d = 1'b1;
    end else begin : g_an_multi
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_an
            assign an_d[gi] = (idx_d == IDX_W'(gi));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            bin_sh_q   <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            blank_lz_q <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            disp_q     <= '0;
            mask_q     <= '0;
        end else begin
            state_q    <= state_d;
            bin_sh_q   <= bin_sh_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            blank_lz_q <= blank_lz_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            disp_q     <= disp_d;
            mask_q     <= mask_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= '0;
            seg_q   <= 7'b1111110;
            an_q    <= DIGITS'(1);
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign busy = (state_q == S_CONV);
    assign done = done_q;
    assign ovf  = ovf_q;
    assign seg  = seg_q;
    assign an   = an_q;

endmodule

// File: tb/tb_bin_bcd_scan_display.sv
// Randomized self-checking bench for bin_bcd_scan_display against an arithmetic
// model of the expected digit, blanking and overflow pattern.
module tb_bin_bcd_scan_display;

    localparam int DIGITS   = 4;
    localparam int WIDTH    = 14;
    localparam int SCAN_DIV = 4;
    localparam int MAXV     = 10 ** DIGITS - 1;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [WIDTH-1:0]  bin;
    logic              blank_lz;
    logic              busy;
    logic              done;
    logic              ovf;
    logic [6:0]        seg;
    logic [DIGITS-1:0] an;

    int checks;
    int errors;

    logic [6:0] seg_tab [0:9] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                  7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                  7'b1111111, 7'b1111011};

    bin_bcd_scan_display #(
        .DIGITS  (DIGITS),
        .WIDTH   (WIDTH),
        .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin     (bin),
        .blank_lz(blank_lz),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf),
        .seg     (seg),
        .an      (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pow10(input int d);
        int p;
        p = 1;
        for (int k = 0; k < d; k++) p = p * 10;
        return p;
    endfunction

    function automatic logic [6:0] model_seg(input int val, input bit blz, input int d);
        if (val > MAXV) return 7'b0000001;
        if (blz && d > 0 && val < pow10(d)) return 7'b0000000;
        return seg_tab[(val / pow10(d)) % 10];
    endfunction

    // Issue one start and follow the conversion; optionally pulse a second start mid-busy.
    task automatic run_conv(input int val, input bit blz, input int ignore_at, input int other_val);
        int cycles;
        int dones;
        start    = 1'b1;
        bin      = WIDTH'(val);
        blank_lz = blz;
        tick();
        start  = 1'b0;
        cycles = 0;
        dones  = 0;
        while (busy && cycles < 200) begin
            if (done) dones++;
            cycles++;
            if (cycles == ignore_at) begin
                start    = 1'b1;
                bin      = WIDTH'(other_val);
                blank_lz = ~blz;
            end
            tick();
            start = 1'b0;
        end
        checks++;
        if (cycles !== WIDTH) begin
            errors++;
            $display("FAIL busy_len val=%0d: got %0d cycles, expected %0d", val, cycles, WIDTH);
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL done_while_busy val=%0d: got %0d pulses, expected 0", val, dones);
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_pulse val=%0d: got %b, expected 1", val, done);
        end
        checks++;
        if (ovf !== (val > MAXV)) begin
            errors++;
            $display("FAIL ovf val=%0d: got %b, expected %b", val, ovf, (val > MAXV));
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_width val=%0d: got done=%b busy=%b, expected 0 0", val, done, busy);
        end
        $display("conv val=%0d blz=%0d cycles=%0d ovf=%b", val, blz, cycles, ovf);
    endtask

    // Watch two full scan rounds; every phase must show the modelled pattern.
    task automatic check_display(input int val, input bit blz);
        logic [DIGITS-1:0] seen;
        int idx;
        seen = '0;
        for (int k = 0; k < 2 * DIGITS * SCAN_DIV; k++) begin
            checks++;
            if (!$onehot(an)) begin
                errors++;
                $display("FAIL an_onehot val=%0d: got %b, expected one-hot", val, an);
            end else begin
                idx = 0;
                for (int i = 0; i < DIGITS; i++) if (an[i]) idx = i;
                seen[idx] = 1'b1;
                checks++;
                if (seg !== model_seg(val, blz, idx)) begin
                    errors++;
                    $display("FAIL seg val=%0d blz=%0d digit=%0d: got %b, expected %b",
                             val, blz, idx, seg, model_seg(val, blz, idx));
                end
            end
            tick();
        end
        checks++;
        if (seen !== {DIGITS{1'b1}}) begin
            errors++;
            $display("FAIL scan_cover val=%0d: got %b, expected all digits", val, seen);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        bin      = '0;
        blank_lz = 1'b0;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got busy=%b done=%b ovf=%b, expected 0 0 0", busy, done, ovf);
        end
        checks++;
        if (an !== 4'b0001 || seg !== 7'b1111110) begin
            errors++;
            $display("FAIL reset_scan: got an=%b seg=%b, expected 0001 1111110", an, seg);
        end
        rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_basic();
        run_conv(1234, 1'b0, 0, 0);
        check_display(1234, 1'b0);
    endtask

    task automatic test_blank();
        run_conv(7, 1'b1, 0, 0);
        check_display(7, 1'b1);
    endtask

    task automatic test_ovf();
        run_conv(12000, 1'b0, 0, 0);
        check_display(12000, 1'b0);
        run_conv(5, 1'b0, 0, 0);
        check_display(5, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_conv(4321, 1'b0, 5, 9876);
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL ignored_start: got done=%b busy=%b, expected 0 0", done, busy);
            end
            tick();
        end
        check_display(4321, 1'b0);
    endtask

    task automatic test_reset_mid();
        int idx;
        start    = 1'b1;
        bin      = WIDTH'(5678);
        blank_lz = 1'b0;
        tick();
        start = 1'b0;
        repeat (6) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy: got %b, expected 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0 || an !== 4'b0001 || seg !== 7'b1111110) begin
            errors++;
            $display("FAIL async_reset: got busy=%b done=%b ovf=%b an=%b seg=%b, expected 0 0 0 0001 1111110",
                     busy, done, ovf, an, seg);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k <= 2 * DIGITS * SCAN_DIV; k++) begin
            idx = (k / SCAN_DIV) % DIGITS;
            checks++;
            if (an !== DIGITS'(1 << idx) || seg !== model_seg(0, 1'b0, idx) || done !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_scan k=%0d: got an=%b seg=%b done=%b, expected an=%b seg=%b done=0",
                         k, an, seg, done, DIGITS'(1 << idx), model_seg(0, 1'b0, idx));
            end
            tick();
        end
        $display("mid-conversion reset checked");
    endtask

    task automatic test_zero();
        run_conv(0, 1'b1, 0, 0);
        check_display(0, 1'b1);
    endtask

    task automatic test_random();
        int val;
        bit blz;
        for (int n = 0; n < 25; n++) begin
            if (n % 3 == 0) val = int'($urandom_range(0, 120));
            else            val = int'($urandom_range(0, (1 << WIDTH) - 1));
            blz = 1'($urandom_range(0, 1));
            run_conv(val, blz, 0, 0);
            check_display(val, blz);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_blank();
        test_ovf();
        test_back_to_back();
        test_reset_mid();
        test_zero();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
